// File: rtl/dct_idct_frame_sequencer.sv
// Frame sequencer for the cascaded dct/idct pair: feeds one frame of
// pixels, qualifies both 64-sample output bursts and ends on drain or timeout.

module dct_idct_burst_qual #(
  parameter int BLOCK_SIZE       = 64,
  parameter int BLOCKS_PER_FRAME = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en_i,
  input  logic                                  clr_i,
  input  logic                                  done_i,
  output logic                                  valid_o,
  output logic [$clog2(BLOCKS_PER_FRAME+1)-1:0] blocks_o,
  output logic [$clog2(BLOCKS_PER_FRAME+1)-1:0] blocks_next_o
);

  localparam int BurstW = $clog2(BLOCK_SIZE+1);
  localparam int BlkW   = $clog2(BLOCKS_PER_FRAME+1);
  localparam logic [BurstW-1:0] Bs   = BurstW'(BLOCK_SIZE);
  localparam logic [BurstW-1:0] BsM1 = BurstW'(BLOCK_SIZE-1);
  localparam logic [BlkW-1:0]   Bpf  = BlkW'(BLOCKS_PER_FRAME);

  logic [BurstW-1:0] cnt_q, cnt_d;
  logic [BlkW-1:0]   blk_q, blk_d;

  assign valid_o       = en_i && done_i && (cnt_q < Bs);
  assign blocks_o      = blk_q;
  assign blocks_next_o = blk_d;

  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q;
    if (en_i) begin
      // run length saturates so an over-long done run yields one block
      if (!done_i)           cnt_d = '0;
      else if (cnt_q != Bs)  cnt_d = cnt_q + BurstW'(1);
      if (valid_o && cnt_q == BsM1 && blk_q != Bpf)
        blk_d = blk_q + BlkW'(1);
    end
    if (clr_i) blk_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

endmodule

module dct_idct_frame_sequencer #(
  parameter int BitWidth         = 31,
  parameter int BLOCK_SIZE       = 64,
  parameter int BLOCKS_PER_FRAME = 1024,
  parameter int DRAIN_LIMIT      = 16384
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  frame_go,
  input  logic                                  pix_valid,
  input  logic [BitWidth:0]                     pix_data,
  output logic                                  pix_ready,
  output logic                                  dct_start,
  output logic [BitWidth:0]                     dct_din,
  input  logic                                  dct_reading,
  input  logic                                  dct_done,
  input  logic                                  idct_done,
  output logic                                  dct_out_valid,
  output logic                                  idct_out_valid,
  output logic [$clog2(BLOCKS_PER_FRAME+1)-1:0] blocks_dct,
  output logic [$clog2(BLOCKS_PER_FRAME+1)-1:0] blocks_idct,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  timeout
);

  localparam int TotW = $clog2(BLOCK_SIZE*BLOCKS_PER_FRAME+1);
  localparam int DrnW = $clog2(DRAIN_LIMIT+1);
  localparam int BlkW = $clog2(BLOCKS_PER_FRAME+1);
  localparam logic [TotW-1:0] Total = TotW'(BLOCK_SIZE*BLOCKS_PER_FRAME);
  localparam logic [DrnW-1:0] Limit = DrnW'(DRAIN_LIMIT);
  localparam logic [BlkW-1:0] Bpf   = BlkW'(BLOCKS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TotW-1:0] in_cnt_q, in_cnt_d;
  logic [DrnW-1:0] drain_cnt_q, drain_cnt_d, drain_inc;
  logic            timeout_q, timeout_d;
  logic            start_frame;
  logic            qual_en;
  logic [BlkW-1:0] blk_dct_nx, blk_idct_nx;

  assign dct_din    = pix_data;
  assign busy       = (state_q == S_FEED) || (state_q == S_FLUSH) ||
                      (state_q == S_DRAIN);
  assign frame_done = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign qual_en    = (state_q != S_IDLE);
  assign drain_inc  = drain_cnt_q + DrnW'(1);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q;
    pix_ready   = 1'b0;
    dct_start   = 1'b0;
    start_frame = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_go) begin
          state_d     = S_FEED;
          in_cnt_d    = '0;
          drain_cnt_d = '0;
          timeout_d   = 1'b0;
          start_frame = 1'b1;
        end
      end
      S_FEED: begin
        dct_start = 1'b1;
        pix_ready = dct_reading && (in_cnt_q < Total);
        if (pix_valid && pix_ready) begin
          in_cnt_d = in_cnt_q + TotW'(1);
          if (in_cnt_d == Total) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        dct_start   = dct_reading;
        drain_cnt_d = drain_inc;
        if (drain_inc == Limit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!dct_reading) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_inc;
        // a block finishing on the limit cycle still counts as a clean end
        if (blk_idct_nx == Bpf) begin
          state_d = S_DONE;
        end else if (drain_inc == Limit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  dct_idct_burst_qual #(
    .BLOCK_SIZE      (BLOCK_SIZE),
    .BLOCKS_PER_FRAME(BLOCKS_PER_FRAME)
  ) u_dct_qual (
    .clk          (clk),
    .rst_n        (reset),
    .en_i         (qual_en),
    .clr_i        (start_frame),
    .done_i       (dct_done),
    .valid_o      (dct_out_valid),
    .blocks_o     (blocks_dct),
    .blocks_next_o(blk_dct_nx)
  );

  dct_idct_burst_qual #(
    .BLOCK_SIZE      (BLOCK_SIZE),
    .BLOCKS_PER_FRAME(BLOCKS_PER_FRAME)
  ) u_idct_qual (
    .clk          (clk),
    .rst_n        (reset),
    .en_i         (qual_en),
    .clr_i        (start_frame),
    .done_i       (idct_done),
    .valid_o      (idct_out_valid),
    .blocks_o     (blocks_idct),
    .blocks_next_o(blk_idct_nx)
  );

endmodule

// File: tb/tb_dct_idct_frame_sequencer.sv
// Bench for dct_idct_frame_sequencer: random pixel/handshake stimulus
// compared every cycle against a frame-level reference model.

module tb_dct_idct_frame_sequencer;

  localparam int BW    = 15;
  localparam int BS    = 64;
  localparam int BPF   = 2;
  localparam int LIMIT = 400;
  localparam int TOTAL = BS * BPF;

  localparam int M_IDLE  = 0;
  localparam int M_FEED  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_go, pix_valid, dct_reading, dct_done, idct_done;
  logic [BW:0]   pix_data;
  logic          pix_ready, dct_start, dct_out_valid, idct_out_valid;
  logic [BW:0]   dct_din;
  logic [1:0]    blocks_dct, blocks_idct;
  logic          busy, frame_done, timeout;

  int n_chk, n_fail;
  int m_st, m_in, m_bd, m_bi, m_nd, m_ni, m_drn;
  bit m_to;
  int n_acc, n_dv, n_iv, n_busy;
  bit o_busy, o_fd;

  always #5 clk = ~clk;

  dct_idct_frame_sequencer #(
    .BitWidth        (BW),
    .BLOCK_SIZE      (BS),
    .BLOCKS_PER_FRAME(BPF),
    .DRAIN_LIMIT     (LIMIT)
  ) u_dut (
    .clk           (clk),
    .reset         (rst_n),
    .frame_go      (frame_go),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .dct_start     (dct_start),
    .dct_din       (dct_din),
    .dct_reading   (dct_reading),
    .dct_done      (dct_done),
    .idct_done     (idct_done),
    .dct_out_valid (dct_out_valid),
    .idct_out_valid(idct_out_valid),
    .blocks_dct    (blocks_dct),
    .blocks_idct   (blocks_idct),
    .busy          (busy),
    .frame_done    (frame_done),
    .timeout       (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] obs_vec();
    return {pix_ready, dct_start, dct_out_valid, idct_out_valid,
            busy, frame_done, timeout, blocks_dct, blocks_idct};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_in = 0; m_bd = 0; m_bi = 0;
    m_nd = 0; m_ni = 0; m_drn = 0; m_to = 0;
  endtask

  task automatic cyc(input bit go, input bit pv, input bit rd,
                     input bit dd, input bit id);
    logic [BW:0] pd;
    bit e_rdy, e_st, e_dv, e_iv, e_busy, acc;
    @(negedge clk);
    pd = (BW+1)'($urandom);
    frame_go = go; pix_valid = pv; pix_data = pd;
    dct_reading = rd; dct_done = dd; idct_done = id;
    #1;
    e_rdy  = (m_st == M_FEED) && rd && (m_in < TOTAL);
    e_st   = (m_st == M_FEED) || (m_st == M_FLUSH && rd);
    e_dv   = (m_st != M_IDLE) && dd && (m_bd < BS);
    e_iv   = (m_st != M_IDLE) && id && (m_bi < BS);
    e_busy = (m_st == M_FEED) || (m_st == M_FLUSH) || (m_st == M_DRAIN);
    chk("outs", 64'(obs_vec()),
        64'({e_rdy, e_st, e_dv, e_iv, e_busy, m_st == M_DONE, m_to,
             2'(m_nd), 2'(m_ni)}));
    acc = pv && pix_ready;
    if (acc) begin
      n_acc++;
      chk("din", 64'(dct_din), 64'(pd));
    end
    if (dct_out_valid) n_dv++;
    if (idct_out_valid) n_iv++;
    o_busy = busy;
    o_fd   = frame_done;
    @(posedge clk);
    if (m_st != M_IDLE) begin
      if (e_dv && m_bd == BS-1 && m_nd < BPF) m_nd++;
      if (e_iv && m_bi == BS-1 && m_ni < BPF) m_ni++;
      m_bd = dd ? ((m_bd < BS) ? m_bd + 1 : BS) : 0;
      m_bi = id ? ((m_bi < BS) ? m_bi + 1 : BS) : 0;
    end
    case (m_st)
      M_IDLE, M_DONE: if (go) begin
        m_st = M_FEED; m_in = 0; m_nd = 0; m_ni = 0; m_drn = 0; m_to = 0;
      end
      M_FEED: if (pv && e_rdy) begin
        m_in++;
        if (m_in == TOTAL) m_st = M_FLUSH;
      end
      M_FLUSH: begin
        m_drn++;
        if (m_drn == LIMIT) begin m_st = M_DONE; m_to = 1; end
        else if (!rd) m_st = M_DRAIN;
      end
      M_DRAIN: begin
        m_drn++;
        if (m_ni == BPF) m_st = M_DONE;
        else if (m_drn == LIMIT) begin m_st = M_DONE; m_to = 1; end
      end
      default: ;
    endcase
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    frame_go = 0; pix_valid = 0; pix_data = '0;
    dct_reading = 0; dct_done = 0; idct_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 64'(obs_vec()), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // idle ignores everything but frame_go
    repeat (4) cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // frame A: random feed, long/short/normal bursts, clean finish
    cyc(1, 0, 0, 0, 0);
    n_acc = 0;
    for (int k = 0; k < 3000 && m_in < TOTAL; k++)
      cyc(0, 1'($urandom), 1'($urandom), 0, 0);
    chk("feedA_accepts", 64'(n_acc), 64'(TOTAL));
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_dv = 0; n_iv = 0;
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, i < 64);
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("dv_run100", 64'(n_dv), 64'(64));
    chk("iv_run64", 64'(n_iv), 64'(64));
    chk("blk_dct_1", 64'(blocks_dct), 64'(1));
    chk("blk_idct_1", 64'(blocks_idct), 64'(1));
    n_dv = 0;
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("dv_run30", 64'(n_dv), 64'(30));
    chk("blk_dct_hold", 64'(blocks_dct), 64'(1));
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1, 1);
    #1;
    chk("done_latency", 64'(frame_done), 64'(1));
    chk("timeout_A", 64'(timeout), 64'(0));
    chk("blk_dct_2", 64'(blocks_dct), 64'(2));
    chk("blk_idct_2", 64'(blocks_idct), 64'(2));
    cyc(0, 0, 0, 0, 0);

    // restart from DONE clears counters, start rises after one cycle
    cyc(1, 0, 0, 0, 0);
    #1;
    chk("restart_blk", 64'({blocks_dct, blocks_idct}), 64'(0));
    chk("restart_to", 64'(timeout), 64'(0));
    chk("restart_start", 64'(dct_start), 64'(1));

    // frame B: go during FEED ignored, toggling back-pressure, timeout
    n_acc = 0;
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 3000 && m_in < TOTAL; k++)
      cyc(0, 1'($urandom), (k % 2) == 0, 0, 0);
    chk("feedB_accepts", 64'(n_acc), 64'(TOTAL));
    n_busy = 0;
    for (int k = 0; k < 600; k++) begin
      cyc(0, 0, k < 3, 0, 0);
      if (o_fd) break;
      if (o_busy) n_busy++;
    end
    chk("to_reached_done", 64'(o_fd), 64'(1));
    chk("to_drain_cycles", 64'(n_busy), 64'(LIMIT));
    chk("to_flag", 64'(timeout), 64'(1));
    chk("to_blk_idct", 64'(blocks_idct), 64'(0));

    // frame C: asynchronous reset in the middle of FEED
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 64'(obs_vec()), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
